// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants, types and the hex-to-segment table for the
//                four-digit multiplexed seven-segment scan driver.
//                Segment vectors are active-low, bit 6 = a ... bit 0 = g.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    // Index 15 is the leftmost element of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h38,  // F
        7'h30,  // E
        7'h42,  // d
        7'h31,  // C
        7'h60,  // b
        7'h08,  // A
        7'h04,  // 9
        7'h00,  // 8
        7'h0F,  // 7
        7'h20,  // 6
        7'h24,  // 5
        7'h4C,  // 4
        7'h06,  // 3
        7'h12,  // 2
        7'h4F,  // 1
        7'h01   // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_decode
//  Description : Purely combinational hex nibble to active-low seven-segment
//                pattern lookup.
//  Ports       : i_nibble [3:0] - hex digit to display
//                o_seg_n  [6:0] - active-low segments, [6]=a ... [0]=g
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode (
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg_n
);
    import seg_pkg::*;

    always_comb begin
        o_seg_n = SEG_TABLE[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Four-digit multiplexed seven-segment driver with double
//                buffered display value, PWM brightness and leading-zero
//                blanking. Digits are scanned 3,2,1,0; each slot lasts
//                DIGIT_DIV clocks and is split into eight equal phases.
//  Ports       : clk         - clock, rising edge
//                rst_n       - asynchronous active-low reset
//                load        - strobe capturing value into the pending buffer
//                value[15:0] - four hex nibbles, [15:12] is the leftmost digit
//                brightness  - on-time is (brightness+1)/8 of each slot
//                seg_n[6:0]  - registered active-low segments
//                anode_n[3:0]- registered active-low digit enables
//                frame_done  - one-cycle pulse marking each frame boundary
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGIT_DIV   = 100000,
    parameter int BLANK_ZEROS = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        load,
    input  wire logic [15:0] value,
    input  wire logic [2:0]  brightness,
    output logic      [6:0]  seg_n,
    output logic      [3:0]  anode_n,
    output logic             frame_done
);
    import seg_pkg::*;

    localparam int c_presc_w   = $clog2(DIGIT_DIV);
    localparam int c_phase_len = DIGIT_DIV / 8;
    localparam int c_sub_w     = (c_phase_len > 1) ? $clog2(c_phase_len) : 1;

    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(DIGIT_DIV - 1);
    localparam logic [c_sub_w-1:0]   c_sub_max   = c_sub_w'(c_phase_len - 1);

    // Registered state
    logic [15:0]           r_pending_q,    w_pending_d;
    logic [15:0]           r_active_q,     w_active_d;
    digit_idx_t            r_digit_q,      w_digit_d;
    logic [c_presc_w-1:0]  r_presc_q,      w_presc_d;
    logic [c_sub_w-1:0]    r_sub_q,        w_sub_d;
    logic [2:0]            r_phase_q,      w_phase_d;
    logic [2:0]            r_bright_q,     w_bright_d;
    logic [6:0]            r_seg_n_q,      w_seg_n_d;
    logic [NUM_DIGITS-1:0] r_anode_n_q,    w_anode_n_d;
    logic                  r_frame_done_q, w_frame_done_d;

    // Combinational helpers
    logic       w_slot_end;
    logic       w_sub_end;
    logic       w_boundary;
    logic       w_blank;
    logic [3:0] w_nibble;
    logic [6:0] w_dec_seg;

    seg_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg_n  (w_dec_seg)
    );

    always_comb begin
        w_slot_end = (r_presc_q == c_presc_max);
        w_sub_end  = (r_sub_q == c_sub_max);
        w_boundary = w_slot_end && (r_digit_q == '0);

        // Slot timing: prescaler spans the slot, the sub-counter spans one
        // eighth of it and advances the phase. Both restart with every slot
        // so the phase can never drift against the slot.
        w_presc_d = w_slot_end ? '0 : r_presc_q + 1'b1;
        w_sub_d   = (w_slot_end || w_sub_end) ? '0 : r_sub_q + 1'b1;
        w_phase_d = w_slot_end ? 3'd0 : (w_sub_end ? r_phase_q + 3'd1 : r_phase_q);
        w_digit_d = w_slot_end ? r_digit_q - 1'b1 : r_digit_q;

        // Brightness is latched on the first cycle of a slot. That cycle is
        // always phase 0, which is lit for any brightness, so the stale
        // value in r_bright_q is harmless there.
        w_bright_d = (r_presc_q == '0) ? brightness : r_bright_q;

        // A load on the boundary cycle goes straight through to active.
        w_pending_d = load ? value : r_pending_q;
        w_active_d  = w_boundary ? w_pending_d : r_active_q;

        w_nibble = r_active_q[{r_digit_q, 2'b00} +: 4];

        w_blank = 1'b0;
        if (BLANK_ZEROS != 0) begin
            case (r_digit_q)
                2'd3:    w_blank = (r_active_q[15:12] == 4'h0);
                2'd2:    w_blank = (r_active_q[15:8]  == 8'h00);
                2'd1:    w_blank = (r_active_q[15:4]  == 12'h000);
                default: w_blank = 1'b0;
            endcase
        end

        w_anode_n_d = '1;
        if (!w_blank && (r_phase_q <= r_bright_q)) begin
            w_anode_n_d[r_digit_q] = 1'b0;
        end

        w_seg_n_d      = w_blank ? SEG_BLANK : w_dec_seg;
        w_frame_done_d = w_boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_q    <= '0;
            r_active_q     <= '0;
            r_digit_q      <= 2'd3;
            r_presc_q      <= '0;
            r_sub_q        <= '0;
            r_phase_q      <= 3'd0;
            r_bright_q     <= 3'd0;
            r_seg_n_q      <= SEG_BLANK;
            r_anode_n_q    <= '1;
            r_frame_done_q <= 1'b0;
        end else begin
            r_pending_q    <= w_pending_d;
            r_active_q     <= w_active_d;
            r_digit_q      <= w_digit_d;
            r_presc_q      <= w_presc_d;
            r_sub_q        <= w_sub_d;
            r_phase_q      <= w_phase_d;
            r_bright_q     <= w_bright_d;
            r_seg_n_q      <= w_seg_n_d;
            r_anode_n_q    <= w_anode_n_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    assign seg_n      = r_seg_n_q;
    assign anode_n    = r_anode_n_q;
    assign frame_done = r_frame_done_q;

endmodule
`default_nettype wire
